// File: rtl/instruction_fetch_unit.sv
// Instruction-memory initiator: streams a program into memory (LOAD), then fetches sequentially (FETCH).
// Optional macro IFU_HALT_DETECT_EN: consuming HALT_WORD stops fetch until reset.
module instruction_fetch_unit #(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              CLk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic [31:0]       memoryInput,
    input  logic [31:0]       instruction,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic [31:0]       fetch_instr,
    output logic              halted
);

`ifdef IFU_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_LOAD, S_FETCH, S_HALT} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_out_pc, w_out_pc_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [ADDR_W:0]   r_load_count, w_load_count_nxt;
    logic              r_halted, w_halted_nxt;

    logic w_hold, w_consume, w_halt_go, w_load_full;

    // The write pointer equals the word count while loading; it never reaches 2^ADDR_W in LOAD.
    assign w_load_full = (r_load_count[ADDR_W-1:0] == {ADDR_W{1'b1}});
    assign w_hold      = stall & r_out_valid;
    assign w_consume   = (r_state == S_FETCH) & r_out_valid & ~stall & ~redirect;
    assign w_halt_go   = HALT_EN & w_consume & (instruction == HALT_WORD);

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_out_pc_nxt     = r_out_pc;
        w_out_valid_nxt  = r_out_valid;
        w_load_count_nxt = r_load_count;
        w_halted_nxt     = r_halted;
        load_ready       = 1'b0;
        write            = 1'b0;
        memoryInput      = '0;
        address          = r_out_pc;
        case (r_state)
            S_LOAD: begin
                load_ready = 1'b1;
                address    = r_load_count[ADDR_W-1:0];
                write      = load_valid;
                if (load_valid) begin
                    memoryInput      = load_data;
                    w_load_count_nxt = r_load_count + 1'b1;
                    if (load_last | w_load_full) begin
                        w_state_nxt     = S_FETCH;
                        w_pc_nxt        = '0;
                        w_out_valid_nxt = 1'b0;
                    end
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    address         = redirect_addr;
                    w_out_pc_nxt    = redirect_addr;
                    w_pc_nxt        = redirect_addr + 1'b1;
                    w_out_valid_nxt = 1'b1;
                end else if (w_hold) begin
                    address = r_out_pc;
                end else begin
                    address = r_pc;
                    if (w_halt_go) begin
                        w_state_nxt     = S_HALT;
                        w_out_valid_nxt = 1'b0;
                        w_halted_nxt    = 1'b1;
                    end else begin
                        w_out_pc_nxt    = r_pc;
                        w_pc_nxt        = r_pc + 1'b1;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            S_HALT: address = r_out_pc;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge CLk) begin
        if (reset) begin
            r_state      <= S_LOAD;
            r_pc         <= '0;
            r_out_pc     <= '0;
            r_out_valid  <= 1'b0;
            r_load_count <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_out_pc     <= w_out_pc_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_load_count <= w_load_count_nxt;
            r_halted     <= w_halted_nxt;
        end
    end

    assign load_count  = r_load_count;
    assign fetch_valid = r_out_valid & (r_state == S_FETCH);
    assign fetch_pc    = r_out_pc;
    assign fetch_instr = instruction;
    assign halted      = HALT_EN & r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model, phase-level reference model, directed and random stimulus.
module tb_instruction_fetch_unit;
    localparam int          AW    = 5;
    localparam int          DEPTH = 32;
    localparam logic [31:0] HW    = 32'hFFFF_FFFF;
`ifdef IFU_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 1'b0;
    logic [31:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic [AW:0]   load_count;
    logic [AW-1:0] address;
    logic          write;
    logic [31:0]   memoryInput;
    logic [31:0]   instruction = '0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          fetch_valid;
    logic [AW-1:0] fetch_pc;
    logic [31:0]   fetch_instr;
    logic          halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.ADDR_W(AW), .HALT_WORD(HW)) dut (
        .CLk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .load_count(load_count),
        .address(address), .write(write), .memoryInput(memoryInput),
        .instruction(instruction),
        .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .halted(halted)
    );

    // Synchronous memory: read data is the word at the address of the previous edge.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    always @(posedge clk) begin
        if (write) mem[address] <= memoryInput;
        instruction <= mem[address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=LOAD 1=FETCH 2=HALT; mm is the program as the bench streamed it.
    int          m_ph = 0, m_pc = 0, m_opc = 0, m_cnt = 0;
    bit          m_ov = 0, m_hl = 0, m_ok = 0;
    logic [31:0] mm [DEPTH] = '{default: 32'h0};

    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_pc = 0; m_opc = 0; m_cnt = 0; m_ov = 0; m_hl = 0; m_ok = 1;
        end else if (m_ok) begin
            if (m_ph == 0) begin
                if (load_valid) begin
                    mm[m_cnt] = load_data;
                    m_cnt++;
                    if (load_last || m_cnt == DEPTH) begin
                        m_ph = 1; m_pc = 0; m_ov = 0;
                    end
                end
            end else if (m_ph == 1) begin
                if (redirect) begin
                    m_opc = int'(redirect_addr);
                    m_pc  = (m_opc + 1) % DEPTH;
                    m_ov  = 1;
                end else if (stall && m_ov) begin
                end else if (HALT_EN && m_ov && mm[m_opc] == HW) begin
                    m_ph = 2; m_ov = 0; m_hl = 1;
                end else begin
                    m_opc = m_pc;
                    m_pc  = (m_pc + 1) % DEPTH;
                    m_ov  = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            int ea;
            if (m_ph == 0)                ea = m_cnt % DEPTH;
            else if (m_ph == 2)           ea = m_opc;
            else if (redirect)            ea = int'(redirect_addr);
            else if (stall && m_ov)       ea = m_opc;
            else                          ea = m_pc;
            chk("load_ready",  32'(load_ready),  32'(m_ph == 0));
            chk("write",       32'(write),       32'(m_ph == 0 && load_valid));
            chk("memoryInput", memoryInput,      (m_ph == 0 && load_valid) ? load_data : 32'h0);
            chk("address",     32'(address),     32'(ea));
            chk("load_count",  32'(load_count),  32'(m_cnt));
            chk("fetch_valid", 32'(fetch_valid), 32'(m_ov && m_ph == 1));
            chk("fetch_pc",    32'(fetch_pc),    32'(m_opc));
            if (m_ov && m_ph == 1) chk("fetch_instr", fetch_instr, mm[m_opc]);
            chk("halted",      32'(halted),      32'(m_hl));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        load_valid = 0; load_last = 0; load_data = '0;
        stall = 0; redirect = 0; redirect_addr = '0;
    endtask

    task automatic pulse_reset();
        idle();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    logic [31:0] lw [DEPTH];

    // Streams lw[0..n-1]; optional idle gaps; load_last on the final word when with_last.
    task automatic load_prog(input int n, input bit with_last, input bit gaps);
        int i = 0;
        while (i < n) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                load_valid = 0; load_last = 0;
                cyc();
            end else begin
                load_valid = 1;
                load_data  = lw[i];
                load_last  = with_last && (i == n - 1);
                #1;
                chk("ld_write", 32'(write), 32'h1);
                chk("ld_addr",  32'(address), 32'(i));
                cyc();
                i++;
            end
        end
        load_valid = 0; load_last = 0; load_data = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        #1;
        chk("rst_load_ready",  32'(load_ready),  32'h1);
        chk("rst_load_count",  32'(load_count),  32'h0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst_halted",      32'(halted),      32'h0);

        // Four-word program, straight-line fetch, stall, redirect under stall.
        lw[0] = 32'h11; lw[1] = 32'h22; lw[2] = 32'h33; lw[3] = 32'h44;
        load_prog(4, 1, 0);
        #1;
        chk("p4_load_count", 32'(load_count), 32'd4);
        chk("p4_ready_low",  32'(load_ready), 32'h0);
        chk("p4_first_gap",  32'(fetch_valid), 32'h0);
        cyc(); #1;
        chk("p4_pc0", 32'(fetch_pc), 32'd0); chk("p4_i0", fetch_instr, 32'h11);
        chk("p4_v0", 32'(fetch_valid), 32'h1);
        cyc(); #1;
        chk("p4_pc1", 32'(fetch_pc), 32'd1); chk("p4_i1", fetch_instr, 32'h22);
        cyc(); #1;
        chk("p4_pc2", 32'(fetch_pc), 32'd2); chk("p4_i2", fetch_instr, 32'h33);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_addr",  32'(address),  32'd2);
            chk("stall_pc",    32'(fetch_pc), 32'd2);
            chk("stall_instr", fetch_instr,   32'h33);
            cyc();
        end
        stall = 0;
        #1;
        chk("rel_pc2", 32'(fetch_pc), 32'd2);
        cyc(); #1;
        chk("rel_pc3", 32'(fetch_pc), 32'd3); chk("rel_i3", fetch_instr, 32'h44);
        redirect = 1; redirect_addr = 5'd0; stall = 1;
        #1;
        chk("redir_addr", 32'(address), 32'd0);
        cyc();
        redirect = 0; stall = 0;
        #1;
        chk("redir_pc0", 32'(fetch_pc), 32'd0); chk("redir_i0", fetch_instr, 32'h11);
        chk("redir_v",   32'(fetch_valid), 32'h1);
        cyc(); #1;
        chk("redir_pc1", 32'(fetch_pc), 32'd1);
        cyc(); #1;
        chk("redir_pc2", 32'(fetch_pc), 32'd2);

        // HALT_WORD at address 2: a stall must not halt; consumption halts only with the feature built in.
        pulse_reset();
        lw[0] = 32'h11; lw[1] = 32'h22; lw[2] = HW; lw[3] = 32'h44;
        load_prog(4, 1, 0);
        cyc(); cyc(); cyc();
        stall = 1;
        #1;
        chk("hw_pc2", 32'(fetch_pc), 32'd2);
        cyc();
        stall = 0;
        #1;
        chk("hw_stall_nohalt", 32'(halted), 32'h0);
        chk("hw_stall_valid",  32'(fetch_valid), 32'h1);
        cyc(); #1;
        chk("hw_halted", 32'(halted), 32'(HALT_EN));
        chk("hw_valid",  32'(fetch_valid), 32'(!HALT_EN));
        chk("hw_pc",     32'(fetch_pc), HALT_EN ? 32'd2 : 32'd3);
        repeat (4) cyc();

        // Reset in the middle of fetch, then a one-word reload.
        pulse_reset();
        lw[0] = 32'h5; lw[1] = 32'h6; lw[2] = 32'h7;
        load_prog(3, 1, 0);
        cyc(); cyc();
        #1;
        chk("mid_pc1", 32'(fetch_pc), 32'd1);
        reset = 1;
        cyc();
        reset = 0;
        #1;
        chk("mid_ready", 32'(load_ready), 32'h1);
        chk("mid_valid", 32'(fetch_valid), 32'h0);
        chk("mid_count", 32'(load_count), 32'h0);
        lw[0] = 32'hAB;
        load_prog(1, 1, 0);
        cyc(); #1;
        chk("reload_pc0", 32'(fetch_pc), 32'd0);
        chk("reload_i0",  fetch_instr,   32'hAB);

        // Full memory without load_last, then wrap of the fetch PC.
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) lw[i] = $urandom() & 32'h7FFF_FFFF;
        load_prog(DEPTH, 0, 1);
        #1;
        chk("full_count", 32'(load_count), 32'd32);
        chk("full_ready", 32'(load_ready), 32'h0);
        repeat (32) cyc();
        #1;
        chk("wrap_pc31", 32'(fetch_pc), 32'd31); chk("wrap_i31", fetch_instr, lw[31]);
        cyc(); #1;
        chk("wrap_pc0",  32'(fetch_pc), 32'd0);  chk("wrap_i0",  fetch_instr, lw[0]);

        // Random programs and fetch traffic, checked every cycle by the model.
        for (int it = 0; it < 20; it++) begin
            int n;
            pulse_reset();
            repeat ($urandom_range(0, 3)) cyc();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++)
                lw[i] = ($urandom_range(0, 5) == 0) ? HW : $urandom();
            load_prog(n, (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)), 1);
            for (int c = 0; c < 150; c++) begin
                stall         = ($urandom_range(0, 9) < 3);
                redirect      = ($urandom_range(0, 9) == 0);
                redirect_addr = AW'($urandom_range(0, DEPTH - 1));
                cyc();
            end
            idle();
        end

        idle();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory port: drives `address` / `write` / `memoryInput` and consumes `instruction`. The memory returns `instruction` one clock after `address` is presented. After reset the block runs a LOAD phase, streaming a program into memory over a valid/ready interface. It then runs a FETCH phase that issues sequential word addresses and presents fetched instructions, with their PC, to decode, with stall and redirect support.

Parameters:
ADDR_W, 5, word-address width; memory depth 2^ADDR_W, PC arithmetic modulo 2^ADDR_W
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch (see Optional Feature)

Ports:
CLk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
load_valid  in  1  load word present
load_data  in  32  word to store
load_last  in  1  final word of program, qualified by load_valid
load_ready  out  1  high only in LOAD
load_count  out  ADDR_W+1  number of words written this LOAD phase
address  out  ADDR_W  memory word address
write  out  1  memory write enable
memoryInput  out  32  memory write data
instruction  in  32  memory read data, registered, reflects address of previous edge
stall  in  1  decode cannot accept current instruction
redirect  in  1  branch/jump taken, overrides stall
redirect_addr  in  ADDR_W  redirect target
fetch_valid  out  1  fetch_instr/fetch_pc valid
fetch_pc  out  ADDR_W  address of fetch_instr
fetch_instr  out  32  equals instruction input (pass-through)
halted  out  1  fetch stopped

Behaviour:
- States: LOAD, FETCH, HALT. Reset (any cycle, any state, including mid-load or mid-fetch) forces the following:
  - state=LOAD, pc=0, out_pc=0, out_valid=0, load_ptr=0, load_count=0, halted=0.
  - Memory contents are not cleared.
- LOAD:
  - load_ready=1. address=load_ptr. write=load_valid. memoryInput=load_data while write=1, else 0.
  - Accepted word (load_valid at edge): load_ptr+1, load_count+1.
  - Leave to FETCH after the accepted word if load_last=1, or if load_ptr was 2^ADDR_W-1 (memory full; load_ptr does not wrap).
  - On entry to FETCH: pc=0, out_valid=0.
  - No words accepted means the block stays in LOAD indefinitely.
- FETCH / HALT: load_ready=0, write=0, memoryInput=0.
- hold = stall & out_valid. A stall with nothing presented is ignored.
- address is combinational:
  - redirect=1: address = redirect_addr
  - else hold=1: address = out_pc, so memory re-reads and fetch_instr stays stable
  - else: address = pc
- FETCH edge update:
  - redirect: out_pc<=redirect_addr, pc<=redirect_addr+1, out_valid<=1. The current instruction is discarded. No bubble.
  - else hold: all registers unchanged.
  - else: out_pc<=pc, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0), out_valid<=1.
- fetch_valid = out_valid & (state==FETCH). An instruction is consumed on an edge with fetch_valid=1 and stall=0 and redirect=0.
- First valid instruction appears 2 cycles after entering FETCH (issue address 0, then data at fetch_pc=0).
- HALT: fetch_valid=0, halted=1, address=out_pc, no register changes. Exit only by reset.

Optional Feature:
- Macro IFU_HALT_DETECT_EN.
- Defined: consuming an instruction equal to HALT_WORD moves FETCH->HALT on that edge, out_valid<=0, halted<=1. A stalled or redirected HALT_WORD does not halt.
- Undefined: no HALT state reachable, halted tied 0, HALT_WORD unused.

Test Plan:
- Reset, load 4 words 0x11,0x22,0x33,0x44 (last on 4th), no stall:
  - write pulses at address 0..3, load_count=4.
  - fetch_pc 0,1,2,3 with matching fetch_instr on consecutive cycles, starting 2 cycles after the load_last edge.
- Stall asserted 3 cycles while fetch_pc=2:
  - fetch_pc/fetch_instr held at 2/0x33, address=2 during stall.
  - fetch_pc=3 on the first cycle after release.
- Redirect to 0 while fetch_pc=3, with stall also high:
  - next cycle fetch_pc=0, fetch_instr=0x11, then 1,2.
- Load 32 words without load_last (ADDR_W=5):
  - auto-exit to FETCH after address 31, load_count=32.
  - Fetch wraps pc 31 -> 0.
- With IFU_HALT_DETECT_EN, program word 2 = 0xFFFFFFFF:
  - first stall at fetch_pc=2 keeps halted=0; on release halted=1, fetch_valid=0 next cycle.
  - Without the macro, fetch continues to pc 3.
- reset pulse mid-FETCH at fetch_pc=1:
  - next cycle load_ready=1, fetch_valid=0, load_count=0.
  - Reload one word 0xAB with load_last: fetch_pc=0 returns 0xAB.
